// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache between the fetch stage
// and the memory controller's instruction port. A miss does one single-word fill.
module icache_direct #(
  parameter int NSETS = 16,
  parameter int IDX_W = $clog2(NSETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  // datapath fetch port
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  // memory controller port
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  // statistics
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t state, next_state;

  logic [NSETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [NSETS];
  logic [31:0]      data_q [NSETS];

  logic [31:0]      miss_addr;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  logic hit;
  logic miss_start;
  logic fill_en;

  // The byte offset plays no part in a word-granular cache.
  logic unused_offset;
  assign unused_offset = ^imemaddr[1:0];

  assign req_tag  = imemaddr[31:IDX_W+2];
  assign req_idx  = imemaddr[IDX_W+1:2];
  assign fill_tag = miss_addr[31:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];

  // Lookups are only honoured in IDLE; an outstanding fill masks them.
  assign hit        = (state == IDLE) && imemREN && valid_q[req_idx]
                      && (tag_q[req_idx] == req_tag);
  assign miss_start = (state == IDLE) && imemREN && !hit;
  assign fill_en    = (state == FETCH) && !iwait;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: a default assignment at the top of every combinational block keeps
  // each path fully specified, so no latch can be inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (miss_start) next_state = FETCH;
      FETCH:   if (!iwait)     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    unique case (state)
      IDLE: begin
        ihit     = hit;
        imemload = hit ? data_q[req_idx] : '0;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
      end
      default: ;
    endcase
  end

  // Miss address is captured once and held, so a redirect cannot disturb
  // the fill already in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)           miss_addr <= '0;
    else if (miss_start) miss_addr <= {imemaddr[31:2], 2'b00};
  end

  // Valid bits clear on reset; reset is asynchronous so a fill can never
  // land on the reset cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        valid_q           <= '0;
    else if (fill_en) valid_q[fill_idx] <= 1'b1;
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide
  // whether their contents are meaningful, which lets them map onto RAM.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (miss_start && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end

endmodule
